encode_ri_golomb_serializer: RTL

ENCODE_RI_GOLOMB_SERIALIZER -- requirements
Module: encode_ri_golomb_serializer

---
 rtl/encode_ri_golomb_serializer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/encode_ri_golomb_serializer.sv
// encode_ri_golomb_serializer
// Serialises one JPEG-LS run-interruption Golomb codeword into MSB-aligned
// beats of at most CHUNK_W bits. Each symbol is emitted as:
//   HDR   : '0' followed by the J LSBs of the run count
//   ZEROS : Z unary zeros, CHUNK_W bits per beat at most (skipped if Z=0)
//   TAIL  : '1' followed by the suffix, flagged out_last
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   in_valid/in_ready           symbol handshake (ready only while idle)
//   in_merrval/in_k/in_j/in_runcnt  symbol fields, captured on handshake
//   out_valid/out_ready         beat handshake
//   out_bits/out_len            MSB-aligned beat payload and its valid bit count
//   out_last/out_overflow       final beat of symbol / symbol is escape coded
//   err_j                       sticky flag: an out-of-range J was clipped
module encode_ri_golomb_serializer #(
  parameter int LIMIT    = 32,
  parameter int QBPP     = 8,
  parameter int MERR_W   = 9,
  parameter int K_W      = 4,
  parameter int J_W      = 5,
  parameter int RUNCNT_W = 16,
  parameter int CHUNK_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MERR_W-1:0]         in_merrval,
  input  logic [K_W-1:0]            in_k,
  input  logic [J_W-1:0]            in_j,
  input  logic [RUNCNT_W-1:0]       in_runcnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK_W-1:0]        out_bits,
  output logic [$clog2(CHUNK_W):0]  out_len,
  output logic                      out_last,
  output logic                      out_overflow,
  output logic                      err_j
);

  localparam int LEN_W = $clog2(CHUNK_W) + 1;
  localparam int ZW    = $clog2(LIMIT + 1) + 1;

  typedef enum logic [1:0] {IDLE, HDR, ZEROS, TAIL} state_t;

  state_t               state_q, state_d;
  logic [ZW-1:0]        zrem_q, zrem_d;
  logic [CHUNK_W-1:0]   tail_bits_q, tail_bits_d;
  logic [LEN_W-1:0]     tail_len_q, tail_len_d;
  logic                 out_valid_q, out_valid_d;
  logic [CHUNK_W-1:0]   out_bits_q, out_bits_d;
  logic [LEN_W-1:0]     out_len_q, out_len_d;
  logic                 out_last_q, out_last_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 err_j_q, err_j_d;

  // Capture-side codeword parameters, derived straight from the inputs
  int                   j_int, thr, z_int, sl;
  logic                 j_bad, esc;
  logic [MERR_W-1:0]    unary_v, merr_m1;
  logic [CHUNK_W-1:0]   one_c, sfx_src, sfx_mask, tail_word, hdr_word;
  logic [ZW-1:0]        zrem_next;
  logic                 hs;

  // Zero-beat length: min(remaining zeros, CHUNK_W)
  function automatic logic [LEN_W-1:0] zlen(input logic [ZW-1:0] z);
    if (int'(z) > CHUNK_W) return LEN_W'(CHUNK_W);
    return LEN_W'(z);
  endfunction

  always_comb begin
    one_c = CHUNK_W'(1);
    j_int = int'(in_j);
    j_bad = (j_int > CHUNK_W - 1);
    if (j_bad) j_int = CHUNK_W - 1;
    unary_v = in_merrval >> in_k;
    merr_m1 = in_merrval - MERR_W'(1);
    // Escape threshold: glimit - QBPP - 1, with glimit = LIMIT - J - 1
    thr = LIMIT - j_int - QBPP - 2;
    esc = (int'(unary_v) >= thr);
    if (esc) begin
      z_int   = (thr < 0) ? 0 : thr;
      sl      = QBPP;
      sfx_src = CHUNK_W'(merr_m1);
    end else begin
      z_int   = int'(unary_v);
      sl      = int'(in_k);
      sfx_src = CHUNK_W'(in_merrval);
    end
    sfx_mask  = (one_c << sl) - one_c;
    // '1' marker sits just above the suffix; the whole field is left-justified
    tail_word = ((sfx_src & sfx_mask) | (one_c << sl)) << (CHUNK_W - 1 - sl);
    // Leading '0' is implicit: J run-count bits start one below the MSB
    hdr_word  = (CHUNK_W'(in_runcnt) & ((one_c << j_int) - one_c)) << (CHUNK_W - 1 - j_int);
  end

  always_comb begin
    state_d     = state_q;
    zrem_d      = zrem_q;
    tail_bits_d = tail_bits_q;
    tail_len_d  = tail_len_q;
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    out_len_d   = out_len_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    err_j_d     = err_j_q;
    zrem_next   = zrem_q - ZW'(out_len_q);
    hs          = out_valid_q && out_ready;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = HDR;
          out_valid_d = 1'b1;
          out_bits_d  = hdr_word;
          out_len_d   = LEN_W'(j_int + 1);
          out_last_d  = 1'b0;
          out_ovf_d   = esc;
          zrem_d      = ZW'(z_int);
          tail_bits_d = tail_word;
          tail_len_d  = LEN_W'(sl + 1);
          if (j_bad) err_j_d = 1'b1;
        end
      end
      HDR: begin
        if (hs) begin
          if (zrem_q != '0) begin
            state_d    = ZEROS;
            out_bits_d = '0;
            out_len_d  = zlen(zrem_q);
          end else begin
            state_d    = TAIL;
            out_bits_d = tail_bits_q;
            out_len_d  = tail_len_q;
            out_last_d = 1'b1;
          end
        end
      end
      ZEROS: begin
        if (hs) begin
          zrem_d = zrem_next;
          if (zrem_next == '0) begin
            state_d    = TAIL;
            out_bits_d = tail_bits_q;
            out_len_d  = tail_len_q;
            out_last_d = 1'b1;
          end else begin
            out_len_d  = zlen(zrem_next);
          end
        end
      end
      TAIL: begin
        if (hs) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_bits_d  = '0;
          out_len_d   = '0;
          out_last_d  = 1'b0;
          out_ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over any handshake in the same cycle, aborting the symbol
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      zrem_q      <= '0;
      tail_bits_q <= '0;
      tail_len_q  <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_len_q   <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      err_j_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      zrem_q      <= zrem_d;
      tail_bits_q <= tail_bits_d;
      tail_len_q  <= tail_len_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_len_q   <= out_len_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
      err_j_q     <= err_j_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign out_bits     = out_bits_q;
  assign out_len      = out_len_q;
  assign out_last     = out_last_q;
  assign out_overflow = out_ovf_q;
  assign err_j        = err_j_q;

endmodule
